stepper_ramp_gen: RTL and testbench
===================================

// Module: stepper_ramp_gen
// PURPOSE
//  Trapezoidal motion-profile generator feeding the stepper phase sequencer.
//  - Accepts move commands (step count + direction) over a valid/ready handshake.
//  - Emits one-cycle step pulses whose spacing ramps from MAX_INTERVAL down to MIN_INTERVAL
//    and back, so the motor starts and stops without stalling.
//  - The downstream sequencer advances its coil phase once per step pulse, in direction_ccw.
// PARAMETERS
//  MAX_INTERVAL   54000  clocks between steps at start/stop speed (500 pps at 27 MHz)
//  MIN_INTERVAL   27000  clocks between steps at cruise speed (1000 pps at 27 MHz); 2 <= MIN <= MAX
//  ACCEL_STEP     100    interval change applied per step while ramping
//  COUNT_BITS     16     width of step count
//  INTERVAL_BITS  $clog2(MAX_INTERVAL+ACCEL_STEP+1)  derived; holds interval with no overflow
// PORTS
//  clock          in   1            system clock
//  reset          in   1            synchronous, active-high
//  cmd_valid      in   1            move command present
//  cmd_ready      out  1            block can accept a command (== state IDLE)
//  cmd_steps      in   COUNT_BITS   number of steps to issue
//  cmd_ccw        in   1            direction of the move, 1 = CCW
//  abort          in   1            request controlled deceleration to stop
//  step           out  1            one-cycle step pulse to the phase sequencer
//  direction_ccw  out  1            direction for the current/last move
//  busy           out  1            high while a move is in progress (state RUN)
//  steps_done     out  COUNT_BITS   steps issued since the last accepted command
// BEHAVIOUR
//  Reset: state=IDLE, step=0, direction_ccw=0, busy=0, steps_done=0, internal counters 0.
//  cmd_ready=0 while reset is high; reset mid-move stops all pulses immediately.
//  Outputs are registered except cmd_ready, which is decoded from state.
//  IDLE: on cmd_valid&&cmd_ready:
//   - latch direction_ccw=cmd_ccw; clear steps_done.
//   - cmd_steps==0: stay IDLE, no pulse.
//   - otherwise: remaining=cmd_steps, interval=MAX_INTERVAL, counter=0, ramp=0, go RUN.
//  RUN:
//   - counter increments each cycle; cmd_valid is ignored (cmd_ready=0).
//   - when counter==interval-1: counter<=0, step<=1 for exactly one cycle,
//     remaining-=1, steps_done+=1.
//   - First pulse is high exactly MAX_INTERVAL cycles after the accept cycle.
//   - Interval update on each step, using r = remaining after decrement:
//     - r==0: go IDLE on the same edge that raises the final step; cmd_ready=1 while it is high.
//     - r<=ramp: decelerate; interval=min(interval+ACCEL_STEP, MAX_INTERVAL); ramp-=1, saturating at 0.
//     - else if interval>MIN_INTERVAL: accelerate; interval=max(interval-ACCEL_STEP, MIN_INTERVAL); ramp+=1.
//     - else: cruise; interval and ramp are unchanged.
//   - Short moves give a triangular profile, because deceleration begins before MIN_INTERVAL is reached.
//  abort (level, sampled every cycle; ignored in IDLE):
//   - in RUN: remaining <= min(remaining', ramp'+1), where ' is the value after any same-cycle step update.
//   - The motor decelerates symmetrically and stops; steps_done reports the true count.
//   - If the same-cycle step update makes r==0, go IDLE as normal.
//  steps_done holds its value after completion until the next accepted command.
// TESTING (MAX_INTERVAL=20, MIN_INTERVAL=10, ACCEL_STEP=5)
//  1. cmd_steps=0, cmd_valid 1 cycle -> no step, busy stays 0, steps_done=0, cmd_ready stays 1.
//  2. cmd_steps=1, cmd_ccw=1 -> single step 20 cycles after accept; busy falls with it;
//     direction_ccw=1; steps_done=1.
//  3. cmd_steps=10 -> step spacings 20,15,10,10,10,10,10,10,15,20; last step 130 cycles after accept.
//  4. cmd_steps=100, abort 1 cycle after the 4th step -> remaining clamps to 3;
//     spacings then 10,15,20; steps_done=7; busy falls with the 7th step.
//  5. cmd_valid held during a move with cmd_steps=5 -> ignored; re-accepted when cmd_ready returns.
//  6. Reset asserted mid-move -> step=0 and busy=0 the next cycle; steps_done=0; no further pulses.

Source files
------------

// File: rtl/stepper_ramp_gen_if.sv
// Move-command channel into the stepper ramp generator.
//   cmd_valid  master -> slave  a move command is presented
//   cmd_ready  slave -> master  generator is idle and will take the command
//   cmd_steps  master -> slave  number of steps to issue
//   cmd_ccw    master -> slave  direction of the move, 1 = CCW
interface stepper_ramp_gen_if #(
   parameter int COUNT_BITS = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [COUNT_BITS-1:0] cmd_steps;
   logic                  cmd_ccw;

   modport master (
      output cmd_valid,
      output cmd_steps,
      output cmd_ccw,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_steps,
      input  cmd_ccw,
      output cmd_ready
   );
endinterface

// File: rtl/stepper_ramp_gen.sv
// Trapezoidal motion-profile generator for the stepper phase sequencer.
// Takes a move command (step count + direction) and emits one-cycle step
// pulses whose spacing ramps from MAX_INTERVAL down to MIN_INTERVAL and back
// up again, so the motor starts and stops without stalling. Abort requests a
// controlled, symmetric deceleration to standstill.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   cmd            command channel (slave side): valid/ready/steps/ccw
//   abort          level request to decelerate and stop (ignored when idle)
//   step           one-cycle step pulse to the phase sequencer
//   direction_ccw  direction of the current/last move
//   busy           a move is in progress
//   steps_done     steps issued since the last accepted command
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high (unless in reset)
// RUN   | move in progress; counting out the interval between steps
module stepper_ramp_gen #(
   parameter int MAX_INTERVAL  = 54000,
   parameter int MIN_INTERVAL  = 27000,
   parameter int ACCEL_STEP    = 100,
   parameter int COUNT_BITS    = 16,
   parameter int INTERVAL_BITS = $clog2(MAX_INTERVAL + ACCEL_STEP + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   stepper_ramp_gen_if.slave     cmd,
   input  logic                  abort,
   output logic                  step,
   output logic                  direction_ccw,
   output logic                  busy,
   output logic [COUNT_BITS-1:0] steps_done
);

   localparam int IW = INTERVAL_BITS;
   localparam int CB = COUNT_BITS;

   localparam logic [IW-1:0] MAX_I = IW'(MAX_INTERVAL);
   localparam logic [IW-1:0] MIN_I = IW'(MIN_INTERVAL);
   localparam logic [IW-1:0] ACC_I = IW'(ACCEL_STEP);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state,     state_nxt;
   logic [IW-1:0]   counter,   counter_nxt;
   logic [IW-1:0]   interval,  interval_nxt;
   logic [CB-1:0]   ramp,      ramp_nxt;
   logic [CB-1:0]   remaining, remaining_nxt;
   logic [CB-1:0]   r_dec;
   logic            step_nxt;
   logic            dir_nxt;
   logic            busy_nxt;
   logic [CB-1:0]   done_nxt;

   // Decoded rather than registered so the handshake tracks state directly;
   // held low during reset so nothing is accepted on the reset edge.
   assign cmd.cmd_ready = (state == IDLE) && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         counter       <= '0;
         interval      <= '0;
         ramp          <= '0;
         remaining     <= '0;
         step          <= 1'b0;
         direction_ccw <= 1'b0;
         busy          <= 1'b0;
         steps_done    <= '0;
      end else begin
         state         <= state_nxt;
         counter       <= counter_nxt;
         interval      <= interval_nxt;
         ramp          <= ramp_nxt;
         remaining     <= remaining_nxt;
         step          <= step_nxt;
         direction_ccw <= dir_nxt;
         busy          <= busy_nxt;
         steps_done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      counter_nxt   = counter;
      interval_nxt  = interval;
      ramp_nxt      = ramp;
      remaining_nxt = remaining;
      step_nxt      = 1'b0;
      dir_nxt       = direction_ccw;
      done_nxt      = steps_done;
      r_dec         = remaining - CB'(1);

      case (state)
         IDLE: begin
            if (cmd.cmd_valid && cmd.cmd_ready) begin
               dir_nxt  = cmd.cmd_ccw;
               done_nxt = '0;
               if (cmd.cmd_steps != '0) begin
                  remaining_nxt = cmd.cmd_steps;
                  interval_nxt  = MAX_I;
                  counter_nxt   = '0;
                  ramp_nxt      = '0;
                  state_nxt     = RUN;
               end
            end
         end

         RUN: begin
            counter_nxt = counter + IW'(1);
            if (counter == interval - IW'(1)) begin
               counter_nxt   = '0;
               step_nxt      = 1'b1;
               remaining_nxt = r_dec;
               done_nxt      = steps_done + CB'(1);
               if (r_dec == '0) begin
                  state_nxt = IDLE;
               end else if (r_dec <= ramp) begin
                  // Decelerate: the steps left are just enough to unwind the
                  // accelerations already taken.
                  interval_nxt = (interval + ACC_I > MAX_I) ? MAX_I : interval + ACC_I;
                  ramp_nxt     = (ramp == '0) ? '0 : ramp - CB'(1);
               end else if (interval > MIN_I) begin
                  // Compare before subtracting so the interval never wraps.
                  interval_nxt = (interval > MIN_I + ACC_I) ? interval - ACC_I : MIN_I;
                  ramp_nxt     = ramp + CB'(1);
               end
            end
            // Abort keeps only the steps needed to ramp back down, so the
            // stop is as gentle as the normal end of a move.
            if (abort && state_nxt == RUN) begin
               if (remaining_nxt > ramp_nxt + CB'(1)) begin
                  remaining_nxt = ramp_nxt + CB'(1);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt == RUN);
   end

endmodule

// File: tb/tb_stepper_ramp_gen.sv
module tb_stepper_ramp_gen;

   localparam int MAXI = 20;
   localparam int MINI = 10;
   localparam int ACC  = 5;
   localparam int CB   = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          abort;
   logic          step;
   logic          direction_ccw;
   logic          busy;
   logic [CB-1:0] steps_done;

   int checks = 0;
   int errors = 0;
   int exp_sp[$];
   int last_t;

   stepper_ramp_gen_if #(.COUNT_BITS(CB)) cmd_if ();

   stepper_ramp_gen #(
      .MAX_INTERVAL(MAXI),
      .MIN_INTERVAL(MINI),
      .ACCEL_STEP  (ACC),
      .COUNT_BITS  (CB)
   ) dut (
      .clock        (clk),
      .reset        (reset),
      .cmd          (cmd_if.slave),
      .abort        (abort),
      .step         (step),
      .direction_ccw(direction_ccw),
      .busy         (busy),
      .steps_done   (steps_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Step-level profile: list of gaps between successive pulses (the first
   // measured from the accept edge). abort_k>0 means abort arrives between
   // pulse abort_k and the next one.
   function automatic void model(input int n, input int abort_k);
      int iv, rp, rem, k;
      exp_sp.delete();
      iv  = MAXI;
      rp  = 0;
      rem = n;
      k   = 0;
      while (rem > 0) begin
         k++;
         exp_sp.push_back(iv);
         rem--;
         if (rem == 0) break;
         if (rem <= rp) begin
            iv = (iv + ACC > MAXI) ? MAXI : iv + ACC;
            rp = (rp > 0) ? rp - 1 : 0;
         end else if (iv > MINI) begin
            iv = (iv - ACC < MINI) ? MINI : iv - ACC;
            rp++;
         end
         if (k == abort_k && rem > rp + 1) rem = rp + 1;
      end
   endfunction

   task automatic count_pulses(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (step) pulses++;
      end
   endtask

   task automatic run_move(input int n, input bit ccw, input int abort_k);
      int cyc, seen, last, limit, extra;
      model(n, abort_k);
      limit = MAXI * (n + 2) + 50;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = CB'(n);
      cmd_if.cmd_ccw   = ccw;
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'(n != 0));
      chk("ready_after_accept", 32'(cmd_if.cmd_ready), 32'(n == 0));
      chk("direction", 32'(direction_ccw), 32'(ccw));
      cyc  = 0;
      seen = 0;
      last = 0;
      while (seen < exp_sp.size() && cyc < limit) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         abort = 1'b0;
         if (step) begin
            chk("spacing", cyc - last, exp_sp[seen]);
            last = cyc;
            seen++;
            if (seen == abort_k) abort = 1'b1;
            if (seen == exp_sp.size()) begin
               chk("busy_at_last_step", 32'(busy), 0);
               chk("ready_at_last_step", 32'(cmd_if.cmd_ready), 1);
            end
         end
      end
      abort = 1'b0;
      last_t = last;
      chk("step_count", seen, exp_sp.size());
      chk("steps_done", 32'(steps_done), exp_sp.size());
      count_pulses(2 * MAXI, extra);
      chk("no_extra_pulses", extra, 0);
      chk("steps_done_hold", 32'(steps_done), exp_sp.size());
      chk("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      int pulses, seen, cyc, n, ab;
      bit dir;

      reset            = 1'b1;
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_steps = '0;
      cmd_if.cmd_ccw   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_step", 32'(step), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_steps_done", 32'(steps_done), 0);
      chk("rst_ready_low", 32'(cmd_if.cmd_ready), 0);
      chk("rst_dir", 32'(direction_ccw), 0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_if.cmd_ready), 1);

      // zero-step command
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = '0;
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      count_pulses(MAXI + 5, pulses);
      chk("zero_no_pulse", pulses, 0);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_steps_done", 32'(steps_done), 0);
      chk("zero_ready", 32'(cmd_if.cmd_ready), 1);

      // single step, CCW
      run_move(1, 1'b1, 0);
      chk("single_at_20", last_t, 20);

      // ten steps: full trapezoid
      run_move(10, 1'b0, 0);
      chk("ten_last_at_130", last_t, 130);

      // abort after 4th step of a long move
      run_move(100, 1'b0, 4);
      chk("abort_total_7", 32'(steps_done), 7);

      // cmd_valid held through a move is ignored, then re-accepted
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = CB'(5);
      cmd_if.cmd_ccw   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready_low", 32'(cmd_if.cmd_ready), 0);
      seen = 0;
      cyc  = 0;
      while (seen < 5 && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (step) seen++;
         if (seen < 5 && cmd_if.cmd_ready) chk("hold_ready_during_move", 32'(cmd_if.cmd_ready), 0);
      end
      chk("hold_first_move_steps", seen, 5);
      chk("hold_steps_done_5", 32'(steps_done), 5);
      chk("hold_ready_back", 32'(cmd_if.cmd_ready), 1);
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      chk("reaccept_busy", 32'(busy), 1);
      chk("reaccept_cleared", 32'(steps_done), 0);
      seen = 0;
      cyc  = 0;
      while (seen < 5 && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (step) seen++;
      end
      chk("reaccept_steps", seen, 5);
      chk("reaccept_steps_done", 32'(steps_done), 5);
      repeat (2) @(negedge clk);

      // reset mid-move
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = CB'(10);
      cmd_if.cmd_ccw   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      repeat (30) @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_step", 32'(step), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_steps_done", 32'(steps_done), 0);
      reset = 1'b0;
      count_pulses(3 * MAXI, pulses);
      chk("reset_no_pulses", pulses, 0);
      chk("reset_ready", 32'(cmd_if.cmd_ready), 1);

      // randomized moves, some aborted
      for (int t = 0; t < 8; t++) begin
         n   = $urandom_range(1, 30);
         dir = 1'($urandom_range(0, 1));
         ab  = ($urandom_range(0, 2) == 0 && n > 1) ? $urandom_range(1, n - 1) : 0;
         run_move(n, dir, ab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
